// File: rtl/pc_sequencer.sv
// Instruction-fetch PC sequencer: IDLE/REQ request FSM with jr/jump/branch redirect.
// Optional macro DELAY_SLOT_EN delivers the instruction fetched with the redirecting ack.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  output logic        fetch_req,
  output logic [31:0] fetch_addr,
  input  logic        fetch_ack,
  input  logic [31:0] fetch_instr,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        jr,
  input  logic [31:0] jr_target,
  input  logic        branch_taken,
  input  logic [15:0] branch_offset,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic        instr_valid
);

  // state  | meaning
  // IDLE   | no request outstanding; waits for stall=0
  // REQ    | fetch_req=1, fetch_addr=pc held until fetch_ack
  typedef enum logic {S_IDLE = 1'b0, S_REQ = 1'b1} state_t;

  state_t      state_q;
  logic        req_q;
  logic [31:0] pc_q;
  logic        pend_q;
  logic [31:0] pend_tgt_q;
  logic [31:0] instr_q;
  logic        instr_valid_q;

  logic        redir_any;
  logic [31:0] redir_tgt;
  logic [31:0] br_off;
  logic        ack_take;
  logic        redirect_now;
  logic        kill;
  logic [31:0] pc_d;

  // Branch offset is a signed word count, scaled to bytes.
  assign br_off    = {{14{branch_offset[15]}}, branch_offset, 2'b00};
  assign redir_any = jr | jump | branch_taken;
  assign ack_take  = (state_q == S_REQ) && fetch_ack;

  always_comb begin
    redir_tgt = pc_q + br_off;
    if (jr) begin
      redir_tgt = jr_target;
    end else if (jump) begin
      redir_tgt = {pc_q[31:28], jump_index, 2'b00};
    end
  end

  // A pending target always beats a fresh pulse arriving with the ack.
  always_comb begin
    redirect_now = pend_q | redir_any;
    if (pend_q) begin
      pc_d = pend_tgt_q;
    end else if (redir_any) begin
      pc_d = redir_tgt;
    end else begin
      pc_d = pc_q + 32'd4;
    end
  end

`ifdef DELAY_SLOT_EN
  assign kill = 1'b0;
`else
  assign kill = redirect_now;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      req_q         <= 1'b0;
      pc_q          <= RESET_PC;
      pend_q        <= 1'b0;
      pend_tgt_q    <= 32'h0;
      instr_q       <= 32'h0;
      instr_valid_q <= 1'b0;
    end else begin
      instr_valid_q <= 1'b0;
      if (ack_take) begin
        pc_q   <= pc_d;
        pend_q <= 1'b0;
        if (!kill) begin
          instr_q       <= fetch_instr;
          instr_valid_q <= 1'b1;
        end
      end else if (redir_any && !pend_q) begin
        pend_q     <= 1'b1;
        pend_tgt_q <= redir_tgt;
      end

      case (state_q)
        S_IDLE: begin
          if (!stall) begin
            state_q <= S_REQ;
            req_q   <= 1'b1;
          end
        end
        S_REQ: begin
          if (fetch_ack && stall) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign fetch_req   = req_q;
  assign fetch_addr  = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed pins plus randomized traffic against a behavioural model.
module tb_pc_sequencer;

`ifdef DELAY_SLOT_EN
  localparam bit DS = 1'b1;
`else
  localparam bit DS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_ack;
  logic [31:0] fetch_instr;
  logic        jump;
  logic [25:0] jump_index;
  logic        jr;
  logic [31:0] jr_target;
  logic        branch_taken;
  logic [15:0] branch_offset;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        instr_valid;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_ack(fetch_ack), .fetch_instr(fetch_instr),
    .jump(jump), .jump_index(jump_index),
    .jr(jr), .jr_target(jr_target),
    .branch_taken(branch_taken), .branch_offset(branch_offset),
    .pc(pc), .instr(instr), .instr_valid(instr_valid)
  );

  // Behavioural model: "busy" means a request is outstanding.
  logic        m_busy, m_pend, m_valid;
  logic [31:0] m_pc, m_tgt, m_instr;
  logic        n_busy, n_pend, n_valid;
  logic [31:0] n_pc, n_tgt, n_instr, t;
  logic        any;

  always_comb begin
    any = jr | jump | branch_taken;
    if (jr)        t = jr_target;
    else if (jump) t = (m_pc & 32'hF000_0000) | (32'(jump_index) * 32'd4);
    else           t = m_pc + 32'($signed(branch_offset)) * 32'd4;
    n_busy = m_busy; n_pend = m_pend; n_tgt = m_tgt;
    n_pc = m_pc; n_instr = m_instr; n_valid = 1'b0;
    if (m_busy && fetch_ack) begin
      n_pc   = m_pend ? m_tgt : (any ? t : m_pc + 32'd4);
      n_pend = 1'b0;
      n_busy = !stall;
      if (!((m_pend || any) && !DS)) begin
        n_instr = fetch_instr;
        n_valid = 1'b1;
      end
    end else begin
      if (any && !m_pend) begin
        n_pend = 1'b1;
        n_tgt  = t;
      end
      if (!m_busy && !stall) n_busy = 1'b1;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_pend <= 1'b0; m_tgt <= 32'h0;
      m_pc <= 32'h0; m_instr <= 32'h0; m_valid <= 1'b0;
    end else begin
      m_busy <= n_busy; m_pend <= n_pend; m_tgt <= n_tgt;
      m_pc <= n_pc; m_instr <= n_instr; m_valid <= n_valid;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
    chk("m_fetch_req", 32'(fetch_req), 32'(m_busy));
    chk("m_fetch_addr", fetch_addr, m_pc);
    chk("m_pc", pc, m_pc);
    chk("m_instr", instr, m_instr);
    chk("m_instr_valid", 32'(instr_valid), 32'(m_valid));
  endtask

  task automatic drive(input logic s, input logic a, input logic j, input logic [25:0] ji,
                       input logic r, input logic [31:0] rt, input logic b, input logic [15:0] bo);
    stall = s; fetch_ack = a; jump = j; jump_index = ji;
    jr = r; jr_target = rt; branch_taken = b; branch_offset = bo;
    fetch_instr = $urandom;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step(); step();
    chk("rst_pc", pc, 32'h0);
    chk("rst_req", 32'(fetch_req), 32'h0);
    chk("rst_valid", 32'(instr_valid), 32'h0);
    chk("rst_instr", instr, 32'h0);

    rst_n = 1'b1;
    drive(0, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("seq_addr", fetch_addr, 32'(i * 4));
      chk("seq_req", 32'(fetch_req), 32'h1);
      chk("seq_valid", 32'(instr_valid), (i > 0) ? 32'h1 : 32'h0);
      fetch_instr = $urandom;
    end

    drive(0, 1, 0, 0, 1, 32'h0040_0010, 0, 0);
    step();
    chk("jr_pc", pc, 32'h0040_0010);
    chk("jr_slot", 32'(instr_valid), 32'(DS));
    drive(0, 1, 1, 26'h0000100, 0, 0, 0, 0);
    step();
    chk("jump_pc", pc, 32'h0000_0400);
    drive(0, 1, 0, 0, 1, 32'h0000_0100, 0, 0);
    step();
    drive(0, 1, 0, 0, 0, 0, 1, 16'hFFFC);
    step();
    chk("branch_pc", pc, 32'h0000_00F0);
    drive(0, 1, 1, 26'h3FFFFFF, 1, 32'h1234_5678, 0, 0);
    step();
    chk("prio_pc", pc, 32'h1234_5678);

    drive(0, 0, 1, 26'h0000010, 0, 0, 0, 0);
    step();
    chk("pend_hold_pc", pc, 32'h1234_5678);
    drive(0, 0, 0, 0, 1, 32'h0000_DEAD, 0, 0);
    step();
    drive(0, 1, 0, 0, 0, 0, 0, 0);
    step();
    chk("pend_pc", pc, 32'h1000_0040);
    chk("pend_slot", 32'(instr_valid), 32'(DS));

    drive(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("wait_req", 32'(fetch_req), 32'h1);
      chk("wait_addr", fetch_addr, 32'h1000_0040);
    end
    fetch_ack = 1'b1;
    step();
    chk("stall_idle_req", 32'(fetch_req), 32'h0);
    chk("stall_idle_pc", pc, 32'h1000_0044);
    fetch_ack = 1'b0;
    step();
    chk("stall_hold_req", 32'(fetch_req), 32'h0);
    stall = 1'b0;
    step();
    chk("unstall_req", 32'(fetch_req), 32'h1);

    drive(0, 1, 0, 0, 1, 32'hFFFF_FFFC, 0, 0);
    step();
    drive(0, 1, 0, 0, 0, 0, 0, 0);
    step();
    chk("wrap_pc", pc, 32'h0);
    fetch_ack = 1'b0;
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("async_req", 32'(fetch_req), 32'h0);
    chk("async_pc", pc, 32'h0);
    step();
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    chk("post_rst_req", 32'(fetch_req), 32'h1);
    chk("post_rst_addr", fetch_addr, 32'h0);

    for (int i = 0; i < 3000; i++) begin
      drive(($urandom % 4) == 0, ($urandom % 2) == 0,
            ($urandom % 8) == 0, 26'($urandom),
            ($urandom % 10) == 0, $urandom,
            ($urandom % 8) == 0, 16'($urandom));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
